// File: rtl/bsg_router_inject_arbiter.sv
// Inject-port arbiter: shares one router P input among num_req_p local
// requesters. Packets are a header flit plus L body flits (L taken from the
// header's length field). Arbitration is round-robin between packets, and a
// multi-flit packet holds the port until its last body flit is sent.
//
// Handshake: valid/ready on every link. A flit moves on a cycle where valid
// and ready are both high. Valid never waits on ready. A source holds its
// valid and data until it is accepted. Flits pass straight through with no
// storage, so v_o/data_o are a combinational mux of the grantee's inputs.
module bsg_router_inject_arbiter #(
  parameter int num_req_p    = 4,
  parameter int width_p      = 256,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               v_i,
  input  logic [num_req_p-1:0][width_p-1:0]  data_i,
  output logic [num_req_p-1:0]               ready_and_o,
  output logic                               v_o,
  output logic [width_p-1:0]                 data_o,
  input  logic                               ready_and_i,
  output logic                               busy_o,
  output logic [$clog2(num_req_p)-1:0]       owner_o
);

  localparam int ptr_w_lp = $clog2(num_req_p);

  // IDLE: arbitrating between packets. LOCKED: streaming the owner's body.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ptr_w_lp-1:0]    ptr_q, ptr_d;
  logic [ptr_w_lp-1:0]    owner_q, owner_d;
  logic [len_width_p-1:0] cnt_q, cnt_d;

  // Held low from reset assertion until the first clock edge after release,
  // so the release is taken up synchronously and the outputs stay quiet.
  logic                   active_q;

  logic                   rr_found;
  logic [ptr_w_lp-1:0]    rr_idx;
  logic                   gnt_v;
  logic [ptr_w_lp-1:0]    gnt_idx;
  logic                   xfer;
  logic [len_width_p-1:0] hdr_len;

  // Index after idx, wrapping num_req_p-1 to 0 (works for any num_req_p).
  function automatic logic [ptr_w_lp-1:0] next_idx(input logic [ptr_w_lp-1:0] idx);
    if (int'(idx) == num_req_p - 1) begin
      return '0;
    end
    return idx + ptr_w_lp'(1);
  endfunction

  // Reset-release tracker.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  // Round-robin search: first valid requester starting at ptr_q.
  always_comb begin
    int                  cand;
    logic [ptr_w_lp-1:0] cand_idx;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= num_req_p) begin
        cand = cand - num_req_p;
      end
      cand_idx = ptr_w_lp'(cand);
      if (!rr_found && v_i[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // Grant selection: the owner while locked, otherwise the round-robin winner.
  // A grant only exists when the chosen requester is valid.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = ptr_q;
    if (active_q) begin
      if (state_q == ST_LOCKED) begin
        gnt_idx = owner_q;
        gnt_v   = v_i[owner_q];
      end else begin
        gnt_idx = rr_idx;
        gnt_v   = rr_found;
      end
    end
  end

  // Output mux and per-requester ready.
  always_comb begin
    v_o     = gnt_v;
    data_o  = data_i[gnt_idx];
    busy_o  = (state_q == ST_LOCKED);
    owner_o = gnt_idx;
    for (int i = 0; i < num_req_p; i++) begin
      ready_and_o[i] = gnt_v & ready_and_i & (gnt_idx == ptr_w_lp'(i));
    end
  end

  assign xfer    = gnt_v & ready_and_i;
  assign hdr_len = data_o[len_offset_p +: len_width_p];

  // Next-state logic: packet framing and round-robin pointer advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (hdr_len == '0) begin
            ptr_d = next_idx(gnt_idx);
          end else begin
            state_d = ST_LOCKED;
            owner_d = gnt_idx;
            cnt_d   = hdr_len;
          end
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          if (cnt_q == len_width_p'(1)) begin
            state_d = ST_IDLE;
            ptr_d   = next_idx(owner_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - len_width_p'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_router_inject_arbiter.sv
// Bench for bsg_router_inject_arbiter: directed packet streams from per-
// requester flit queues, a packet-level reference model checked every cycle,
// and hand-computed acceptance orders and literal output expectations.
module tb_bsg_router_inject_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (4 requesters, length field at [7:4]) ----------------
  logic [3:0]       v_i;
  logic [3:0][31:0] data_i;
  logic [3:0]       ready_and_o;
  logic             v_o;
  logic [31:0]      data_o;
  logic             rdy;
  logic             busy_o;
  logic [1:0]       owner_o;

  bsg_router_inject_arbiter #(
    .num_req_p(4), .width_p(32), .len_width_p(4), .len_offset_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i),
    .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o),
    .ready_and_i(rdy), .busy_o(busy_o), .owner_o(owner_o)
  );

  // ---------------- DUT (3 requesters, pointer wrap) ----------------
  logic [2:0]       v3;
  logic [2:0][31:0] d3;
  logic [2:0]       ready3;
  logic             v3_o;
  logic [31:0]      d3_o;
  logic             rdy3;
  logic             busy3;
  logic [1:0]       owner3;

  bsg_router_inject_arbiter #(
    .num_req_p(3), .width_p(32), .len_width_p(4), .len_offset_p(0)
  ) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v3), .data_i(d3),
    .ready_and_o(ready3), .v_o(v3_o), .data_o(d3_o),
    .ready_and_i(rdy3), .busy_o(busy3), .owner_o(owner3)
  );

  // ---------------- bench state ----------------
  logic [31:0] fq [0:3][$];
  logic [3:0]  stall;
  logic [3:0]  acc_vec;
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Flit format: {src, tag, 8'h00, len, 4'hA}
  function automatic logic [31:0] mk(input int src, input int tag, input int len);
    return {src[7:0], tag[7:0], 8'h00, len[3:0], 4'hA};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      v_i[i]    = (fq[i].size() > 0) && !stall[i];
      data_i[i] = (fq[i].size() > 0) ? fq[i][0] : 32'h0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc_vec[i]) void'(fq[i].pop_front());
    end
    apply();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) > 0 && k < 200) begin
      step();
      k++;
    end
    chk("drain_bound", 32'(k < 200), 32'd1);
  endtask

  task automatic check_log(input string name);
    logic [31:0] e;
    logic [31:0] a;
    chk({name, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 32'hxxxxxxxx;
      chk({name, "_order"}, a, e);
    end
    act_q.delete();
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  bit m_act = 0;
  bit m_lock = 0;
  int m_owner = 0;
  int m_cnt = 0;
  int m_ptr = 0;

  always @(negedge clk) begin
    int g;
    bit ev;
    logic [3:0] er;
    int L;
    if (!rst_n) begin
      m_act = 0; m_lock = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      chk("rst_v_o", 32'(v_o), 32'd0);
      chk("rst_ready_and_o", 32'(ready_and_o), 32'd0);
      chk("rst_busy_o", 32'(busy_o), 32'd0);
      chk("rst_owner_o", 32'(owner_o), 32'd0);
      chk("rst3_v_o", 32'(v3_o), 32'd0);
      chk("rst3_owner_o", 32'(owner3), 32'd0);
      acc_vec = '0;
    end else begin
      g  = m_ptr;
      ev = 0;
      if (m_act) begin
        if (m_lock) begin
          g  = m_owner;
          ev = v_i[g];
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (!ev && v_i[(m_ptr + k) % 4]) begin
              ev = 1;
              g  = (m_ptr + k) % 4;
            end
          end
        end
      end
      er = (ev && rdy) ? (4'b0001 << g) : 4'b0000;
      chk("v_o", 32'(v_o), 32'(ev));
      chk("ready_and_o", 32'(ready_and_o), 32'(er));
      chk("busy_o", 32'(busy_o), 32'(m_lock));
      chk("owner_o", 32'(owner_o), 32'(g));
      if (ev) chk("data_o", data_o, data_i[g]);
      acc_vec = v_i & ready_and_o;
      if (v_o && rdy) act_q.push_back(data_o);
      if (busy_o) busy_cnt++;
      if (ev && rdy) begin
        if (!m_lock) begin
          L = int'(data_i[g][7:4]);
          if (L == 0) begin
            m_ptr = (g + 1) % 4;
          end else begin
            m_lock = 1; m_owner = g; m_cnt = L;
          end
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_lock = 0;
            m_ptr  = (m_owner + 1) % 4;
          end
        end
      end
      m_act = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int seq3 [6];
    v_i = '0; data_i = '0; rdy = 1'b1; stall = '0; acc_vec = '0;
    v3 = '0; d3 = '0; rdy3 = 1'b1;

    // Round-robin over four single-flit requesters, queued while in reset.
    for (int r = 0; r < 4; r++) fq[r].push_back(mk(r, 'h10 + r, 0));
    for (int r = 0; r < 4; r++) fq[r].push_back(mk(r, 'h20 + r, 0));
    apply();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_gates_v_o", 32'(v_o), 32'd0);
    chk("reset_gates_ready", 32'(ready_and_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("release_cycle_v_o", 32'(v_o), 32'd0);
    drain();
    // Expected grants 0,1,2,3,0,1,2,3
    for (int r = 0; r < 4; r++) exp_q.push_back(mk(r, 'h10 + r, 0));
    for (int r = 0; r < 4; r++) exp_q.push_back(mk(r, 'h20 + r, 0));
    check_log("rr4");

    // Req 1 sends a 4-flit packet while 0 and 2 keep requesting.
    busy_cnt = 0;
    fq[0].push_back(mk(0, 'h30, 0));
    fq[0].push_back(mk(0, 'h31, 0));
    fq[1].push_back(mk(1, 'h40, 3));
    fq[1].push_back(mk(1, 'h41, 15));
    fq[1].push_back(mk(1, 'h42, 15));
    fq[1].push_back(mk(1, 'h43, 15));
    fq[2].push_back(mk(2, 'h50, 0));
    fq[2].push_back(mk(2, 'h51, 0));
    apply();
    drain();
    chk("lock_busy_cycles", 32'(busy_cnt), 32'd3);
    exp_q.push_back(mk(0, 'h30, 0));
    exp_q.push_back(mk(1, 'h40, 3));
    exp_q.push_back(mk(1, 'h41, 15));
    exp_q.push_back(mk(1, 'h42, 15));
    exp_q.push_back(mk(1, 'h43, 15));
    exp_q.push_back(mk(2, 'h50, 0));
    exp_q.push_back(mk(0, 'h31, 0));
    exp_q.push_back(mk(2, 'h51, 0));
    check_log("lock");

    // Owner 2 with two body flits left drops valid for 5 cycles.
    fq[2].push_back(mk(2, 'h60, 3));
    fq[2].push_back(mk(2, 'h61, 15));
    fq[2].push_back(mk(2, 'h62, 15));
    fq[2].push_back(mk(2, 'h63, 15));
    apply();
    step();
    step();
    stall[2] = 1'b1;
    fq[0].push_back(mk(0, 'h70, 0));
    apply();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bubble_v_o", 32'(v_o), 32'd0);
      chk("bubble_ready", 32'(ready_and_o), 32'd0);
      chk("bubble_busy", 32'(busy_o), 32'd1);
      chk("bubble_owner", 32'(owner_o), 32'd2);
      step();
    end
    stall[2] = 1'b0;
    apply();
    drain();
    exp_q.push_back(mk(2, 'h60, 3));
    exp_q.push_back(mk(2, 'h61, 15));
    exp_q.push_back(mk(2, 'h62, 15));
    exp_q.push_back(mk(2, 'h63, 15));
    exp_q.push_back(mk(0, 'h70, 0));
    check_log("bubble");

    // Router not ready for 4 cycles with req 3 header pending.
    rdy = 1'b0;
    fq[3].push_back(mk(3, 'h80, 0));
    apply();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_v_o", 32'(v_o), 32'd1);
      chk("stall_data_o", data_o, mk(3, 'h80, 0));
      chk("stall_owner", 32'(owner_o), 32'd3);
      chk("stall_ready", 32'(ready_and_o), 32'd0);
      step();
    end
    rdy = 1'b1;
    #1;
    chk("ready_back_ready", 32'(ready_and_o), 32'b1000);
    drain();
    exp_q.push_back(mk(3, 'h80, 0));
    check_log("stall");

    // Reset pulse while owner 2 is mid-packet.
    fq[2].push_back(mk(2, 'h90, 3));
    fq[2].push_back(mk(2, 'h91, 15));
    fq[2].push_back(mk(2, 'h92, 15));
    fq[2].push_back(mk(2, 'h93, 15));
    apply();
    step();
    step();
    #1;
    chk("prereset_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midpkt_rst_v_o", 32'(v_o), 32'd0);
    chk("midpkt_rst_ready", 32'(ready_and_o), 32'd0);
    chk("midpkt_rst_busy", 32'(busy_o), 32'd0);
    chk("midpkt_rst_owner", 32'(owner_o), 32'd0);
    for (int r = 0; r < 4; r++) fq[r].delete();
    apply();
    step();
    step();
    for (int r = 0; r < 4; r++) fq[r].push_back(mk(r, 'hA0 + r, 0));
    apply();
    step();
    rst_n = 1'b1;
    step();
    #1;
    chk("first_grant_v_o", 32'(v_o), 32'd1);
    chk("first_grant_owner", 32'(owner_o), 32'd0);
    drain();
    exp_q.push_back(mk(2, 'h90, 3));
    exp_q.push_back(mk(2, 'h91, 15));
    for (int r = 0; r < 4; r++) exp_q.push_back(mk(r, 'hA0 + r, 0));
    check_log("reset_mid");

    // Three requesters, single flits: grants 0,1,2,0,1,2.
    seq3 = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 3; i++) d3[i] = 32'(i + 1) << 16;
    v3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("wrap3_owner", 32'(owner3), 32'(seq3[k]));
      chk("wrap3_v_o", 32'(v3_o), 32'd1);
      chk("wrap3_data_o", d3_o, 32'(seq3[k] + 1) << 16);
      chk("wrap3_ready", 32'(ready3), 32'(3'b001 << seq3[k]));
      chk("wrap3_busy", 32'(busy3), 32'd0);
      @(posedge clk);
    end
    v3 = '0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_router_inject_arbiter.md
BSG_ROUTER_INJECT_ARBITER -- requirements
Module: bsg_router_inject_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 4, number of local requesters sharing the router P (inject) port; legal range 2..16.
REQ-002 SHALL have parameter width_p, default 256, flit width matching the router tile link width.
REQ-003 SHALL have parameter len_width_p, default 4, width of the header-flit body-length field.
REQ-004 SHALL have parameter len_offset_p, default 0, LSB position of the length field within a header flit.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n_i  input  1  asynchronous active-low reset.
REQ-008 SHALL have port v_i  input  num_req_p  per-requester flit valid.
REQ-009 SHALL have port data_i  input  num_req_p x width_p  per-requester flit.
REQ-010 SHALL have port ready_and_o  output  num_req_p  per-requester ready; a transfer on requester i occurs when v_i[i] & ready_and_o[i].
REQ-011 SHALL have port v_o  output  1  flit valid toward router P input.
REQ-012 SHALL have port data_o  output  width_p  flit toward router P input.
REQ-013 SHALL have port ready_and_i  input  1  router P ready; a transfer occurs when v_o & ready_and_i.
REQ-014 SHALL have port busy_o  output  1  high while in LOCKED.
REQ-015 SHALL have port owner_o  output  clog2(num_req_p)  index of current grantee; equals rr pointer when no grant.

Function
REQ-016 SHALL implement states IDLE and LOCKED, a round-robin pointer ptr, a body counter cnt (len_width_p bits) and an owner register.
REQ-017 In IDLE, grant SHALL go combinationally to the first requester with v_i set, searching ptr, ptr+1, ... modulo num_req_p.
REQ-018 In LOCKED, grant SHALL go only to the owner register; other requesters' v_i SHALL be ignored.
REQ-019 v_o SHALL equal v_i of the grantee (0 when no grantee); data_o SHALL equal data_i of the grantee (don't-care when v_o=0).
REQ-020 ready_and_o[i] SHALL equal ready_and_i & grant[i]; non-grantees SHALL see 0.
REQ-021 Latency SHALL be zero cycles: flits pass combinationally; no flit storage.
REQ-022 v_o SHALL NOT depend on ready_and_i.
REQ-023 IDLE header transfer with length field L=0: stay IDLE, ptr <= grantee+1 mod num_req_p.
REQ-024 IDLE header transfer with L>0: go LOCKED, owner <= grantee, cnt <= L; ptr unchanged.
REQ-025 LOCKED transfer with cnt>1: cnt <= cnt-1.
REQ-026 LOCKED transfer with cnt==1: go IDLE, ptr <= owner+1 mod num_req_p, cnt <= 0.
REQ-027 No transfer (v_o=0 or ready_and_i=0): all state SHALL hold; owner holds through body-flit bubbles of any length.
REQ-028 Grant in IDLE SHALL be stable while ready_and_i=0 and inputs unchanged; requesters SHALL hold v_i/data_i until accepted.
REQ-029 Maximum packet SHALL be 1 + (2^len_width_p - 1) flits; cnt arithmetic SHALL not wrap.
REQ-030 ptr wrap: num_req_p-1 + 1 SHALL yield 0, including non-power-of-two num_req_p.

Reset
REQ-031 Reset assertion SHALL asynchronously force state=IDLE, ptr=0, cnt=0, owner=0.
REQ-032 While reset_n_i=0, v_o, ready_and_o and busy_o SHALL be 0 and owner_o SHALL be 0.
REQ-033 Reset asserted mid-packet SHALL abandon the lock; after release, arbitration SHALL restart from requester 0.
REQ-034 Deassertion SHALL be consumed synchronously to clk_i; first grant is possible the cycle after release.

Verification
REQ-035 Requesters 0..3 all valid, single-flit packets (L=0), ready_and_i=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-036 Req 1 header L=3 accepted, req 0 and 2 valid throughout -> 4 consecutive flits from req 1, busy_o=1 for 3 cycles, then grant to 2.
REQ-037 LOCKED cnt=2, owner=2, v_i[2] drops 5 cycles while req 0 valid -> v_o=0 and ready_and_o=0 for those cycles, then req 2 body flits resume.
REQ-038 ready_and_i=0 for 4 cycles with req 3 header pending -> v_o=1, data_o stable, state/ptr unchanged; transfer on first ready cycle.
REQ-039 reset_n_i pulsed low during LOCKED owner=2, cnt=2 -> v_o=0 immediately; after release with all valid, first grant to requester 0.
REQ-040 num_req_p=3, L=0 from all -> grant sequence 0,1,2,0 (ptr wrap check).
